// File: rtl/fp_mult_arbiter.sv
// Round-robin share of one fp multiplier among N_REQ requesters; one multiply in flight.
// Overhead IDLE+GRANT+SEND_A+SEND_B+RETURN >= 5 cycles; every handshake stalls until its ack/stb.
module fp_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int GW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]    req_stb,
  output logic [N_REQ-1:0]    req_ack,
  output logic [31:0]         res_z,
  output logic [N_REQ-1:0]    res_stb,
  input  logic [N_REQ-1:0]    res_ack,
  output logic [31:0]         m_a,
  output logic [31:0]         m_b,
  output logic                m_a_stb,
  output logic                m_b_stb,
  input  logic                m_a_ack,
  input  logic                m_b_ack,
  input  logic [31:0]         m_z,
  input  logic                m_z_stb,
  output logic                m_z_ack,
  output logic                busy,
  output logic [GW-1:0]       grant
);

  localparam int NP = 1 << GW;

  typedef enum logic [2:0] {IDLE, GRANT, SEND_A, SEND_B, WAIT_Z, RETURN} state_t;

  state_t        state;
  logic [GW-1:0] last;
  logic [GW-1:0] sel;
  logic          sel_vld;
  logic [GW:0]   cand;
  logic [NP-1:0] req_pad;
  logic [31:0]   a_sel;
  logic [31:0]   b_sel;

  // Padding to 2**GW lets grant index the request vector without width games.
  assign req_pad = NP'(req_stb);

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, last} + (GW+1)'(k + 1);
      if (cand >= (GW+1)'(N_REQ))
        cand = cand - (GW+1)'(N_REQ);
      if (!sel_vld && req_pad[cand[GW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == GW'(i)) begin
        a_sel = req_a[32*i +: 32];
        b_sel = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= GW'(N_REQ - 1);
      grant   <= '0;
      req_ack <= '0;
      res_stb <= '0;
      res_z   <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_a_stb <= 1'b0;
      m_b_stb <= 1'b0;
      m_z_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant   <= sel;
            req_ack <= N_REQ'(1) << sel;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          req_ack <= '0;
          if (req_pad[grant]) begin
            m_a     <= a_sel;
            m_b     <= b_sel;
            m_a_stb <= 1'b1;
            state   <= SEND_A;
          end else begin
            // Requester withdrew: give up the slot without touching the rotation.
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEND_A: begin
          if (m_a_ack) begin
            m_a_stb <= 1'b0;
            m_b_stb <= 1'b1;
            state   <= SEND_B;
          end
        end
        SEND_B: begin
          if (m_b_ack) begin
            m_b_stb <= 1'b0;
            m_z_ack <= 1'b1;
            state   <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (m_z_stb) begin
            res_z   <= m_z;
            m_z_ack <= 1'b0;
            res_stb <= N_REQ'(1) << grant;
            state   <= RETURN;
          end
        end
        RETURN: begin
          if (|(res_stb & res_ack)) begin
            res_stb <= '0;
            last    <= grant;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with behavioural multiplier and requester models.
module tb_fp_mult_arbiter;

  localparam int N  = 4;
  localparam int GW = 3;

  logic            clk;
  logic            rst;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
  logic [31:0]     res_z, m_a, m_b, m_z;
  logic            m_a_stb, m_b_stb, m_a_ack, m_b_ack, m_z_stb, m_z_ack, busy;
  logic [GW-1:0]   grant;

  fp_mult_arbiter #(.N_REQ(N), .GW(GW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
    .m_a(m_a), .m_b(m_b), .m_a_stb(m_a_stb), .m_b_stb(m_b_stb),
    .m_a_ack(m_a_ack), .m_b_ack(m_b_ack),
    .m_z(m_z), .m_z_stb(m_z_stb), .m_z_ack(m_z_ack),
    .busy(busy), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int owner; logic [31:0] z; } ent_t;
  typedef struct { int who; logic [31:0] a; logic [31:0] b; logic [31:0] z; } vec_t;

  ent_t        log_q[$];
  logic [N-1:0] res_hold;
  int          reissue_left;
  int          zcnt;
  int          viol;
  int          ack_cyc[N];
  logic [31:0] la, lb;
  int          n_pass, n_total;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] f;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 10'd1;
    end else begin
      f = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  // Inputs are stable between a negedge and the next posedge, so a snapshot
  // taken on entry is exactly what the coming posedge will see.
  task automatic tick();
    logic [N-1:0] s_qs, s_qa, s_rs, s_ra;
    logic         s_as, s_aa, s_bs, s_ba, s_zs, s_za;
    logic [31:0]  s_ma, s_mb, s_rz;
    ent_t         e;
    s_qs = req_stb; s_qa = req_ack; s_rs = res_stb; s_ra = res_ack;
    s_as = m_a_stb; s_aa = m_a_ack; s_bs = m_b_stb; s_ba = m_b_ack;
    s_zs = m_z_stb; s_za = m_z_ack; s_ma = m_a; s_mb = m_b; s_rz = res_z;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (s_qs[i] && s_qa[i]) begin
        if (reissue_left > 0) reissue_left--;
        else req_stb[i] = 1'b0;
      end
      if (s_rs[i] && s_ra[i]) begin
        e.owner = i;
        e.z     = s_rz;
        log_q.push_back(e);
      end
      if (req_ack[i]) ack_cyc[i]++;
    end
    if (s_as && s_aa) la = s_ma;
    if (zcnt > 0) begin
      zcnt--;
      if (zcnt == 0) begin
        m_z     = fmul(la, lb);
        m_z_stb = 1'b1;
      end
    end
    if (s_bs && s_ba) begin
      lb   = s_mb;
      zcnt = 2;
    end
    if (s_zs && s_za) m_z_stb = 1'b0;
    m_a_ack = m_a_stb;
    m_b_ack = m_b_stb;
    res_ack = res_stb & ~res_hold;
    if ($countones(req_ack) > 1 || $countones(res_stb) > 1) viol++;
  endtask

  task automatic clear_model();
    req_stb = '0; res_hold = '0; res_ack = '0;
    m_a_ack = 1'b0; m_b_ack = 1'b0; m_z_stb = 1'b0; m_z = '0;
    zcnt = 0; reissue_left = 0;
    log_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(int i, logic [31:0] a, logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_stb[i] = 1'b1;
  endtask

  task automatic wait_log(int n, int budget, string name);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check({name, "_done"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  function automatic ent_t pop_log();
    ent_t e;
    e.owner = -1;
    e.z     = 32'hDEADBEEF;
    if (log_q.size() > 0) e = log_q.pop_front();
    return e;
  endfunction

  task automatic check_zero_outputs(string name);
    check({name, "_ctl"}, 32'({req_ack, res_stb, m_a_stb, m_b_stb, m_z_ack, busy, grant}), 32'd0);
    check({name, "_m_a"}, m_a, 32'd0);
    check({name, "_m_b"}, m_b, 32'd0);
    check({name, "_res_z"}, res_z, 32'd0);
  endtask

  vec_t vt[5];
  ent_t e;
  int   cnt[N];
  int   rr_bad;
  int   c;

  initial begin
    vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};  // 2*3
    vt[1] = '{1, 32'h3FC00000, 32'h40000000, 32'h40400000};  // 1.5*2
    vt[2] = '{3, 32'hC0000000, 32'h40800000, 32'hC1000000};  // -2*4
    vt[3] = '{2, 32'h3F000000, 32'h3F000000, 32'h3E800000};  // 0.5*0.5
    vt[4] = '{1, 32'h40400000, 32'h40A00000, 32'h41700000};  // 3*5
    n_pass = 0; n_total = 0; viol = 0;
    req_a = '0; req_b = '0; la = '0; lb = '0;
    for (int i = 0; i < N; i++) ack_cyc[i] = 0;

    rst = 1'b1;
    clear_model();
    tick();
    check_zero_outputs("reset");
    tick();
    rst = 1'b0;

    // Single-requester vectors
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N; i++) ack_cyc[i] = 0;
      issue(vt[v].who, vt[v].a, vt[v].b);
      wait_log(1, 60, $sformatf("vec%0d", v));
      e = pop_log();
      check($sformatf("vec%0d_owner", v), e.owner, vt[v].who);
      check($sformatf("vec%0d_z", v), e.z, vt[v].z);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("vec%0d_ack_cycles", v), ack_cyc[vt[v].who], 32'd1);
    end

    // Full contention from reset: served 0,1,2,3
    do_reset();
    for (int k = 0; k < N; k++) issue(k, 32'h3F800000, 32'h3F800000 + (k == 0 ? 32'd0 : 32'h00800000 * 32'(k) - (k == 3 ? 32'h00400000 : 32'd0)));
    issue(2, 32'h3F800000, 32'h40400000);
    issue(3, 32'h3F800000, 32'h40800000);
    issue(1, 32'h3F800000, 32'h40000000);
    issue(0, 32'h3F800000, 32'h3F800000);
    wait_log(4, 300, "contend");
    e = pop_log(); check("contend0_owner", e.owner, 0); check("contend0_z", e.z, 32'h3F800000);
    e = pop_log(); check("contend1_owner", e.owner, 1); check("contend1_z", e.z, 32'h40000000);
    e = pop_log(); check("contend2_owner", e.owner, 2); check("contend2_z", e.z, 32'h40400000);
    e = pop_log(); check("contend3_owner", e.owner, 3); check("contend3_z", e.z, 32'h40800000);

    // Rotation: after serving 1, 2 beats 0
    issue(1, 32'h40000000, 32'h40000000);
    wait_log(1, 60, "rot_a");
    e = pop_log(); check("rot_a_owner", e.owner, 1); check("rot_a_z", e.z, 32'h40800000);
    issue(0, 32'h40400000, 32'h40400000);
    issue(2, 32'h40000000, 32'h3F000000);
    wait_log(2, 120, "rot_b");
    e = pop_log(); check("rot_b_first", e.owner, 2); check("rot_b_first_z", e.z, 32'h3F800000);
    e = pop_log(); check("rot_b_second", e.owner, 0); check("rot_b_second_z", e.z, 32'h41100000);

    // Sustained contention: 16 ops, last was 0 so order is 1,2,3,0,...
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      issue(i, 32'h3F800000, 32'h40000000);
    end
    reissue_left = 12;
    wait_log(16, 600, "starve");
    rr_bad = 0;
    for (int j = 0; j < 16; j++) begin
      e = pop_log();
      if (e.owner >= 0 && e.owner < N) cnt[e.owner]++;
      if (e.owner != (1 + j) % N || e.z !== 32'h40000000) rr_bad++;
    end
    for (int i = 0; i < N; i++) check($sformatf("starve_cnt%0d", i), cnt[i], 32'd4);
    check("starve_order", rr_bad, 32'd0);
    check("starve_idle_req", 32'(req_stb), 32'd0);

    // Result backpressure
    res_hold[0] = 1'b1;
    issue(0, 32'h40000000, 32'h40400000);
    c = 0;
    while (!res_stb[0] && c < 60) begin tick(); c++; end
    check("bp_reached", 32'(res_stb[0]), 32'd1);
    issue(1, 32'h40A00000, 32'h40000000);
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("bp%0d_res_stb", t), 32'(res_stb), 32'd1);
      check($sformatf("bp%0d_res_z", t), res_z, 32'h40C00000);
      check($sformatf("bp%0d_req_ack", t), 32'(req_ack), 32'd0);
      check($sformatf("bp%0d_m_stb", t), 32'({m_a_stb, m_b_stb, m_z_ack}), 32'd0);
    end
    res_hold = '0;
    wait_log(2, 120, "bp");
    e = pop_log(); check("bp_owner0", e.owner, 0); check("bp_z0", e.z, 32'h40C00000);
    e = pop_log(); check("bp_owner1", e.owner, 1); check("bp_z1", e.z, 32'h41200000);

    // Serve 3 so that last=3, then withdraw 1 in GRANT
    issue(3, 32'h3FC00000, 32'h3FC00000);
    wait_log(1, 60, "pre_wd");
    e = pop_log(); check("pre_wd_z", e.z, 32'h40100000);
    issue(1, 32'h40000000, 32'h40000000);
    tick();
    check("wd_ack", 32'(req_ack), 32'b0010);
    check("wd_grant", 32'(grant), 32'd1);
    req_stb[1] = 1'b0;
    tick();
    check("wd_ack_drop", 32'(req_ack), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_no_a", 32'(m_a_stb), 32'd0);
    issue(1, 32'h40000000, 32'h40000000);
    issue(2, 32'h40400000, 32'h3F800000);
    tick();
    check("wd_no_a2", 32'(m_a_stb), 32'd0);
    wait_log(2, 120, "wd");
    e = pop_log(); check("wd_first", e.owner, 1); check("wd_first_z", e.z, 32'h40800000);
    e = pop_log(); check("wd_second", e.owner, 2); check("wd_second_z", e.z, 32'h40400000);

    // Async reset in SEND_B
    issue(0, 32'h40000000, 32'h40400000);
    c = 0;
    while (!m_b_stb && c < 30) begin tick(); c++; end
    check("rstb_reached", 32'(m_b_stb), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("rst_send_b");
    do_reset();

    // Async reset in WAIT_Z
    issue(0, 32'h40000000, 32'h40400000);
    c = 0;
    while (!m_z_ack && c < 30) begin tick(); c++; end
    check("rstz_reached", 32'(m_z_ack), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("rst_wait_z");
    do_reset();
    for (int t = 0; t < 4; t++) tick();
    check("rst_no_result", 32'(log_q.size()), 32'd0);

    issue(0, 32'h40400000, 32'h40A00000);
    wait_log(1, 60, "post_rst");
    e = pop_log(); check("post_rst_owner", e.owner, 0); check("post_rst_z", e.z, 32'h41700000);

    check("onehot_viol", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
